// File: rtl/odo_div_pkg.sv
// Shared definitions for the odd-ratio divider control slice: widths,
// reset ratio, controller state encoding and the ratio legality rule.
package odo_div_pkg;

  localparam int W         = 4;
  localparam int MIN_RATIO = 3;
  localparam int RATIO_RST = 9;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    WAIT_WRAP,
    SETTLE,
    DONE
  } odo_div_ctrl_state_t;

  // Only odd ratios of at least MIN_RATIO give a symmetric odd-divide output.
  function automatic logic ratio_legal(input logic [31:0] r);
    return r[0] && (r >= 32'(MIN_RATIO));
  endfunction

endpackage

// File: rtl/odo_div_phase_cnt.sv
// Mirror of the divider's internal count: runs 0..ratio-1, flags the wrap
// cycle, and clears on the same load edge that the divider sees.
module odo_div_phase_cnt #(
  parameter int W = odo_div_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] ratio,
  input  logic         load,
  output logic [W-1:0] phase,
  output logic         wrap
);

  assign wrap = (phase == ratio - 1'b1);

  // NOTE: clocked state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (load || wrap) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/odo_div_ratio_ctrl.sv
// Run-time ratio controller: accepts ratio requests, rejects illegal ones,
// swaps the divider ratio only on a wrap boundary, then waits to settle.
module odo_div_ratio_ctrl
  import odo_div_pkg::*;
#(
  parameter int W              = odo_div_pkg::W,
  parameter int RATIO_RST      = odo_div_pkg::RATIO_RST,
  parameter int SETTLE_PERIODS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [W-1:0] req_ratio,
  output logic         req_ready,
  output logic         rsp_done,
  output logic         rsp_err,
  output logic         busy,
  output logic [W-1:0] div_ratio,
  output logic [W-1:0] div_phase,
  output logic         div_load
);

  // The counter only needs to reach SETTLE_PERIODS-1; the final wrap exits.
  localparam int SW = (SETTLE_PERIODS < 2) ? 1 : $clog2(SETTLE_PERIODS);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);

  odo_div_ctrl_state_t state, state_nxt;
  logic [W-1:0]        pend_ratio;
  logic [SW-1:0]       settle_cnt;
  logic                wrap;

  odo_div_phase_cnt #(.W(W)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .ratio (div_ratio),
    .load  (div_load),
    .phase (div_phase),
    .wrap  (wrap)
  );

  // Outputs decode from state and wrap only; inputs reach next-state logic alone.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_done  = 1'b0;
    rsp_err   = 1'b0;
    div_load  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (!ratio_legal(32'(req_ratio)))  state_nxt = ERR;
          else if (req_ratio == div_ratio)   state_nxt = DONE;
          else                               state_nxt = WAIT_WRAP;
        end
      end
      ERR: begin
        rsp_err   = 1'b1;
        state_nxt = IDLE;
      end
      WAIT_WRAP: begin
        if (wrap) begin
          div_load  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (wrap && settle_cnt == SETTLE_LAST) state_nxt = DONE;
      end
      DONE: begin
        rsp_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_ratio <= '0;
      div_ratio  <= W'(RATIO_RST);
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (req_valid && req_ready) pend_ratio <= req_ratio;
      if (div_load) begin
        div_ratio  <= pend_ratio;
        settle_cnt <= '0;
      end else if (state == SETTLE && wrap) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

endmodule
